display_scan_controller: RTL
============================

# display_scan_controller

Four-digit time-multiplexing scanner that sits directly upstream of the 7-segment decoder. It accepts a 16-bit hex value through a valid/ready handshake and holds it in a shadow register. The new value is committed only at a frame boundary, so a display frame never shows a mix of old and new digits. Each slot presents one nibble on `hex_digit` to the decoder and drives one active-low digit-enable, with optional leading-zero blanking.

## Interface
- `CLK_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_LZ`, default 1: 1 enables leading-zero blanking; 0 always shows all four digits.
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `load_valid` input 1: `load_value` is offered this cycle.
- `load_ready` output 1: the block can accept a value this cycle.
- `load_value` input 16: four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `hex_digit` output 4: nibble for the current slot, feeds the decoder's hex input.
- `digit_sel_n` output 4: active-low digit enables, one-hot-low; all-ones when the slot is blanked.
- `blank` output 1: 1 when the current slot is blanked; downstream forces segments off.
- `frame_start` output 1: one-cycle pulse on the cycle the slot index wraps 3→0.

## Operation
- Registers:
  - `presc`, ceil(log2(CLK_DIV)) bits.
  - `idx`, 2 bits.
  - `disp_reg`, 16 bits.
  - `shadow`, 16 bits.
  - `pending`, 1 bit.
- `tick` = (`presc` == CLK_DIV-1).
- `presc` increments every cycle and wraps to 0 on `tick`.
- On `tick`, `idx` advances 0→1→2→3→0 and wraps silently.
- Load handshake:
  - `load_ready` = ~`pending`.
  - A transfer occurs when `load_valid` & `load_ready` at a rising edge. On a transfer, `shadow` <= `load_value` and `pending` <= 1.
  - `load_valid` while `load_ready`=0 is ignored; no value is stored.
- Commit happens on `tick` with `idx`==3, which is the wrap edge:
  - If `pending`=1: `disp_reg` <= `shadow` and `pending` <= 0.
  - If a transfer and a commit edge coincide (only possible when `pending`=0), the transfer loads `shadow` and sets `pending`. No commit happens that edge; the value commits at the next wrap.
- Slot decode is pure combinational from registers; there is no input-to-output combinational path.
  - `hex_digit` = `disp_reg`[4*idx+3 : 4*idx].
  - Digit `i` is blanked iff BLANK_LZ=1, `i` ≠ 0, and all nibbles at positions ≥ `i` are zero. Digit 0 is never blanked.
  - Not blanked: `digit_sel_n` = ~(4'b0001 << `idx`), `blank` = 0.
  - Blanked: `digit_sel_n` = 4'b1111, `blank` = 1, `hex_digit` = 0.
- `frame_start` = registered pulse, high for the one cycle following the wrap edge (`idx`==0 and first cycle of slot 0).
- Reset (async assert, any state, including mid-frame or with a pending load):
  - `presc`=0, `idx`=0, `disp_reg`=0, `shadow`=0, `pending`=0.
  - Outputs: `load_ready`=1, `hex_digit`=0, `digit_sel_n`=4'b1110, `blank`=0, `frame_start`=0.
  - A pending value is discarded.
  - Deassertion is synchronous to `clk` at system level; the first `tick` comes CLK_DIV cycles after the first active edge.

## Timing
- Slot length is exactly CLK_DIV cycles; frame length is 4·CLK_DIV cycles.
- `idx`, `disp_reg` and all slot outputs change only on the edge where `tick`=1.
- `load_ready` falls the cycle after a transfer. It rises the cycle after the commit edge.
- Load-to-display latency: from the transfer edge to the first cycle showing the new value, minimum 1 cycle, maximum 4·CLK_DIV cycles.
- With `load_valid` held high continuously, at most one value is accepted per frame.
- Throughput: one accepted load per frame.

## Test plan
- **Reset:** CLK_DIV=4; assert `rst_n`=0 mid-slot with `pending`=1 → outputs immediately return to reset values (`digit_sel_n`=1110, `load_ready`=1). After release, `idx` first advances exactly 4 cycles later.
- **Scan order:** load 0x1234 with BLANK_LZ=0 → after the next wrap, slots show `hex_digit` 4,3,2,1 with `digit_sel_n` 1110,1101,1011,0111, each held 4 cycles. `frame_start` pulses every 16 cycles.
- **Tear-free commit:** with 0x1234 displayed, load 0xABCD at `idx`=1 → slots 1–3 still show 3,2,1. 0xABCD appears starting at slot 0 after the wrap. `load_ready` is 0 in between.
- **Backpressure:** hold `load_valid`=1 with values changing every cycle → exactly one value is accepted per frame, namely the one present on the cycle `load_ready`=1. The others are dropped.
- **Simultaneous load and wrap:** transfer 0x0F00 on the edge where `idx`=3 and `tick`=1 → no commit that edge. It displays one full frame later.
- **Leading-zero blanking:** BLANK_LZ=1:
  - Load 0x0050 → digits 3 and 2 have `blank`=1 and `digit_sel_n`=1111; digit 1 shows 5 and digit 0 shows 0.
  - Load 0x0000 → only digit 0 is lit, showing 0.

Source files
------------

// File: rtl/display_scan_controller.sv
// Four-digit time-multiplexed scanner for a 7-segment decoder.
// A loaded value waits in a shadow register and is committed only at a frame wrap, so frames never tear.
module display_scan_controller #(
    parameter int CLK_DIV  = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_value,
    output logic [3:0]  hex_digit,
    output logic [3:0]  digit_sel_n,
    output logic        blank,
    output logic        frame_start
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   disp_reg;
    logic [15:0]   shadow;
    logic          pending;

    logic          tick;
    logic          wrap;
    logic          xfer;

    assign tick = (presc == PRESC_MAX);
    assign wrap = tick && (idx == 2'd3);

    // Handshake: a value transfers on any rising edge where load_valid && load_ready.
    // load_ready is simply ~pending, so it never depends on load_valid and offers
    // made while it is low are dropped rather than queued.
    assign load_ready = ~pending;
    assign xfer       = load_valid && !pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= 2'd0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
        end
    end

    // Transfer requires pending=0 and commit requires pending=1, so the two never
    // collide; a transfer on the wrap edge therefore commits one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= 16'h0000;
            disp_reg <= 16'h0000;
            pending  <= 1'b0;
        end else if (xfer) begin
            shadow  <= load_value;
            pending <= 1'b1;
        end else if (wrap && pending) begin
            disp_reg <= shadow;
            pending  <= 1'b0;
        end
    end

    logic [3:0] nib [4];
    logic [3:0] lz_blank;
    logic       cur_blank;

    // lz_blank[i] means nibble i and every nibble above it are zero; digit 0 always lights.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nib[i] = disp_reg[4*i +: 4];
        end
        lz_blank    = 4'b0000;
        lz_blank[3] = BLANK_LZ && (nib[3] == 4'h0);
        lz_blank[2] = lz_blank[3] && (nib[2] == 4'h0);
        lz_blank[1] = lz_blank[2] && (nib[1] == 4'h0);
        lz_blank[0] = 1'b0;
    end

    always_comb begin
        cur_blank = lz_blank[idx];
        blank     = cur_blank;
        if (cur_blank) begin
            hex_digit   = 4'h0;
            digit_sel_n = 4'b1111;
        end else begin
            hex_digit   = nib[idx];
            digit_sel_n = ~(4'b0001 << idx);
        end
    end

endmodule
